// File: rtl/ariane_pkg.sv
// Shared load-path types: operator encoding, per-load metadata record and the
// load data alignment/extension helper (also used by the AMO path).
package ariane_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 4;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        LD  = 4'd1,
        LW  = 4'd2,
        LWU = 4'd3,
        LH  = 4'd4,
        LHU = 4'd5,
        LB  = 4'd6,
        LBU = 4'd7
    } fu_op;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [2:0]               offset;
        fu_op                     operator;
        logic                     killed;
    } ld_meta_t;

    function automatic logic is_load(fu_op op);
        return (op == LD) || (op == LW) || (op == LWU) || (op == LH) ||
               (op == LHU) || (op == LB) || (op == LBU);
    endfunction

    // rdata is the 8-byte aligned word; offset selects the first byte of the load.
    function automatic logic [XLEN-1:0] ld_extend(fu_op op, logic [2:0] offset,
                                                  logic [XLEN-1:0] data);
        logic [XLEN-1:0] s;
        logic [XLEN-1:0] r;
        s = data >> {offset, 3'b000};
        case (op)
            LD:      r = s;
            LW:      r = {{(XLEN-32){s[31]}}, s[31:0]};
            LWU:     r = {{(XLEN-32){1'b0}},  s[31:0]};
            LH:      r = {{(XLEN-16){s[15]}}, s[15:0]};
            LHU:     r = {{(XLEN-16){1'b0}},  s[15:0]};
            LB:      r = {{(XLEN-8){s[7]}},   s[7:0]};
            LBU:     r = {{(XLEN-8){1'b0}},   s[7:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ld_meta_fifo.sv
// In-order queue of outstanding load metadata with tag-kill of the newest
// entry and whole-queue flush marking.
module ld_meta_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned NR_OUTSTANDING = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     flush_i,
    input  logic     push_i,
    input  ld_meta_t push_meta_i,
    input  logic     kill_last_i,
    input  logic     pop_i,
    output ld_meta_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PTR_W = (NR_OUTSTANDING > 1) ? $clog2(NR_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(NR_OUTSTANDING) + 1;

    ld_meta_t             mem_q [NR_OUTSTANDING];
    ld_meta_t             mem_d [NR_OUTSTANDING];
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pop_ok, push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (p == PTR_W'(NR_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(NR_OUTSTANDING - 1) : p - 1'b1;
    endfunction

    assign full_o  = (cnt_q == CNT_W'(NR_OUTSTANDING));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so pushing into a full queue is fine then.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;

        // Marking stale slots too is harmless: a push overwrites the whole record.
        if (flush_i) begin
            for (int i = 0; i < int'(NR_OUTSTANDING); i++) mem_d[i].killed = 1'b1;
        end
        if (kill_last_i && !push_i && !empty_o) mem_d[ptr_dec(wptr_q)].killed = 1'b1;

        if (push_ok) begin
            mem_d[wptr_q]        = push_meta_i;
            mem_d[wptr_q].killed = flush_i | kill_last_i;
            wptr_d               = ptr_inc(wptr_q);
        end
        if (pop_ok) rptr_d = ptr_inc(rptr_q);

        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NR_OUTSTANDING); i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_ok))
        else $error("ld_meta_fifo: push into full queue dropped");

endmodule

// File: rtl/load_response_aligner.sv
// Pairs D$ read responses with queued load metadata and drives the registered
// load writeback (valid pulse, tag, aligned/extended result).
module load_response_aligner
    import ariane_pkg::*;
#(
    parameter int unsigned NR_OUTSTANDING = 2,
    parameter int unsigned XLEN_P         = ariane_pkg::XLEN,
    parameter int unsigned TRANS_ID_BITS  = ariane_pkg::TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [TRANS_ID_BITS-1:0] push_trans_id_i,
    input  logic [2:0]               push_offset_i,
    input  fu_op                     push_op_i,
    input  logic                     kill_last_i,
    output logic                     full_o,
    output logic                     empty_o,
    input  logic                     rvalid_i,
    input  logic [XLEN_P-1:0]        rdata_i,
    output logic                     valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic [XLEN_P-1:0]        result_o
);

    ld_meta_t                 push_meta;
    ld_meta_t                 head;
    logic                     pop;
    logic                     wb;
    logic                     valid_q, valid_d;
    logic [TRANS_ID_BITS-1:0] trans_id_q, trans_id_d;
    logic [XLEN_P-1:0]        result_q, result_d;

    assign push_meta = '{trans_id: push_trans_id_i, offset: push_offset_i,
                         operator: push_op_i, killed: 1'b0};

    ld_meta_fifo #(
        .NR_OUTSTANDING (NR_OUTSTANDING)
    ) i_meta_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (push_i),
        .push_meta_i (push_meta),
        .kill_last_i (kill_last_i),
        .pop_i       (rvalid_i),
        .head_o      (head),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    assign pop = rvalid_i && !empty_o;
    // Killed or flushed responses still pop the queue but never reach writeback.
    assign wb  = pop && !head.killed && !flush_i;

    always_comb begin
        valid_d    = wb;
        trans_id_d = trans_id_q;
        result_d   = result_q;
        if (wb) begin
            trans_id_d = head.trans_id;
            result_d   = ld_extend(head.operator, head.offset, rdata_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            trans_id_q <= '0;
            result_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            trans_id_q <= trans_id_d;
            result_q   <= result_d;
        end
    end

    assign valid_o    = valid_q;
    assign trans_id_o = trans_id_q;
    assign result_o   = result_q;

    a_rvalid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rvalid_i && empty_o))
        else $warning("load_response_aligner: response with no outstanding load dropped");

    a_legal_op: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && !head.killed && !is_load(head.operator)))
        else $error("load_response_aligner: non-load operator at queue head");

endmodule

// File: tb/tb_load_response_aligner.sv
// Scoreboard bench: driver updates a queue-level reference model and pushes
// expected writebacks; a monitor pops and compares on every valid_o.
module tb_load_response_aligner;
    import ariane_pkg::*;

    localparam int N  = 2;
    localparam int TW = ariane_pkg::TRANS_ID_BITS;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          flush_i, push_i, kill_last_i, rvalid_i;
    logic [TW-1:0] push_trans_id_i;
    logic [2:0]    push_offset_i;
    fu_op          push_op_i;
    logic [63:0]   rdata_i;
    logic          full_o, empty_o, valid_o;
    logic [TW-1:0] trans_id_o;
    logic [63:0]   result_o;

    always #5 clk = ~clk;

    load_response_aligner #(.NR_OUTSTANDING(N)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .push_i(push_i),
        .push_trans_id_i(push_trans_id_i), .push_offset_i(push_offset_i),
        .push_op_i(push_op_i), .kill_last_i(kill_last_i), .full_o(full_o),
        .empty_o(empty_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .valid_o(valid_o), .trans_id_o(trans_id_o), .result_o(result_o)
    );

    typedef struct { int tid; int off; fu_op op; bit killed; } ment_t;
    typedef struct { int tid; logic [63:0] res; } exp_t;

    ment_t mq[$];
    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] model_res(fu_op op, int off, logic [63:0] d);
        logic [63:0] s, v;
        int n;
        bit sgn;
        s = d >> (8 * off);
        case (op)
            LD:  return s;
            LW:  begin n = 32; sgn = 1; end
            LWU: begin n = 32; sgn = 0; end
            LH:  begin n = 16; sgn = 1; end
            LHU: begin n = 16; sgn = 0; end
            LB:  begin n = 8;  sgn = 1; end
            default: begin n = 8; sgn = 0; end
        endcase
        v = s % (64'd1 << n);
        if (sgn && v >= (64'd1 << (n - 1))) v = v - (64'd1 << n);
        return v;
    endfunction

    // One clock of stimulus; the model sees the same cycle the DUT does.
    task automatic cyc(input bit p, input int tid, input int off, input fu_op op,
                       input bit kl, input bit fl, input bit rv, input logic [63:0] rd);
        ment_t h, e;
        push_i = p; push_trans_id_i = TW'(tid); push_offset_i = 3'(off); push_op_i = op;
        kill_last_i = kl; flush_i = fl; rvalid_i = rv; rdata_i = rd;
        if (rv && mq.size() > 0) begin
            h = mq.pop_front();
            if (!h.killed && !fl) exp_q.push_back('{tid: h.tid, res: model_res(h.op, h.off, rd)});
        end
        if (fl) foreach (mq[i]) mq[i].killed = 1;
        if (kl && !p && mq.size() > 0) mq[mq.size()-1].killed = 1;
        if (p) begin
            e = '{tid: tid, off: off, op: op, killed: (fl || kl)};
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        push_i = 0; kill_last_i = 0; flush_i = 0; rvalid_i = 0;
        chk("full_o", 64'(full_o), 64'(mq.size() == N));
        chk("empty_o", 64'(empty_o), 64'(mq.size() == 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, LD, 0, 0, 0, 64'h0);
    endtask

    always @(negedge clk) begin
        if (rst_ni && valid_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got trans_id %0d expected no writeback at %0t",
                         trans_id_o, $time);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                n_cmp--;
                chk("trans_id_o", 64'(trans_id_o), 64'(x.tid));
                chk("result_o", result_o, x.res);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 0; push_i = 0; flush_i = 0; kill_last_i = 0; rvalid_i = 0;
        push_trans_id_i = '0; push_offset_i = '0; push_op_i = LD; rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid_o", 64'(valid_o), 64'd0);
        chk("rst trans_id_o", 64'(trans_id_o), 64'd0);
        chk("rst result_o", result_o, 64'd0);
        chk("rst empty_o", 64'(empty_o), 64'd1);
        chk("rst full_o", 64'(full_o), 64'd0);
        rst_ni = 1;

        // Basic LD
        cyc(1, 3, 0, LD, 0, 0, 0, 64'h0);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'h1122334455667788);
        idle(1);
        // LB / LBU / LH with offsets
        cyc(1, 1, 5, LB, 0, 0, 0, 64'h0);
        cyc(1, 2, 5, LBU, 0, 0, 0, 64'h0);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'h0000800000000000);
        cyc(1, 9, 6, LH, 0, 0, 1, 64'h0000800000000000);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'h8001000000000000);
        idle(1);
        // Full with simultaneous push and pop
        cyc(1, 1, 0, LD, 0, 0, 0, 64'h0);
        cyc(1, 2, 0, LW, 0, 0, 0, 64'h0);
        cyc(1, 3, 4, LWU, 0, 0, 1, 64'hA5A5A5A5_0BADF00D);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'hFFFF0000_80000001);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'h87654321_00000000);
        idle(1);
        // Kill last
        cyc(1, 4, 0, LD, 0, 0, 0, 64'h0);
        cyc(1, 5, 0, LD, 0, 0, 0, 64'h0);
        cyc(0, 0, 0, LD, 1, 0, 0, 64'h0);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'h4444);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'h5555);
        idle(1);
        // Flush draining
        cyc(1, 6, 0, LD, 0, 0, 0, 64'h0);
        cyc(1, 7, 0, LD, 0, 0, 0, 64'h0);
        cyc(0, 0, 0, LD, 0, 1, 0, 64'h0);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'h6666);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'h7777);
        cyc(1, 8, 2, LHU, 0, 0, 0, 64'h0);
        cyc(0, 0, 0, LD, 0, 0, 1, 64'h0000_0000_FEDC_0000);
        idle(1);
        // Reset mid-operation
        cyc(1, 10, 0, LD, 0, 0, 0, 64'h0);
        cyc(1, 11, 0, LD, 0, 0, 0, 64'h0);
        rst_ni = 0;
        @(posedge clk);
        #1;
        mq.delete();
        chk("midrst valid_o", 64'(valid_o), 64'd0);
        chk("midrst result_o", result_o, 64'd0);
        chk("midrst empty_o", 64'(empty_o), 64'd1);
        rst_ni = 1;
        cyc(0, 0, 0, LD, 0, 0, 1, 64'hDEAD);
        idle(1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit p, rv, kl, fl;
            int sz;
            rv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            sz = mq.size() - (rv ? 1 : 0);
            p  = (sz < N) && ($urandom_range(0, 2) != 0);
            kl = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 19) == 0);
            cyc(p, int'($urandom_range(0, (1 << TW) - 1)), int'($urandom_range(0, 7)),
                fu_op'($urandom_range(1, 7)), kl, fl, rv, {$urandom, $urandom});
        end
        while (mq.size() > 0) cyc(0, 0, 0, LD, 0, 0, 1, {$urandom, $urandom});
        idle(2);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
